muldiv_unit: RTL and testbench
==============================

// Module: muldiv_unit
// PURPOSE
//  Iterative RV32M multiply/divide unit. Consumes the two source operands read from
//  the register file (read_data1/read_data2), computes MUL/MULH/MULHSU/MULHU/DIV/DIVU/
//  REM/REMU over multiple cycles, and drives the register-file write port.
//  Sits between operand read and writeback; the core stalls on busy.
// PARAMETERS
//  XLEN  32  operand/result width; iteration count = XLEN
// PORTS
//  clk         in   1     clock, all state updates on rising edge
//  rst         in   1     synchronous, active-high reset
//  start       in   1     request; sampled only in IDLE
//  funct3      in   3     000 MUL,001 MULH,010 MULHSU,011 MULHU,100 DIV,101 DIVU,110 REM,111 REMU
//  rs1_val     in   XLEN  operand A (from regfile read_data1)
//  rs2_val     in   XLEN  operand B (from regfile read_data2)
//  rd_in       in   5     destination register index
//  busy        out  1     high in CALC and DONE; core holds the instruction
//  done        out  1     one-cycle completion pulse
//  wEn         out  1     regfile write enable (to regfile wEn)
//  rd          out  5     regfile write index
//  write_data  out  XLEN  regfile write data
// BEHAVIOUR
//  Reset: one clk, synchronous, active-high. State=IDLE; busy, done, wEn=0; rd=0;
//   write_data=0; counter, accumulators cleared. Reset mid-CALC aborts, no write.
//  FSM IDLE -> CALC -> DONE -> IDLE. All outputs registered.
//  IDLE: on start=1 at edge 0, latch funct3, rd_in, operand magnitudes and sign flags;
//   counter=0; go CALC. start ignored in CALC/DONE (not queued).
//  Special cases, decided at edge 0, go straight to DONE (done in cycle T+1):
//   div/rem by zero: DIV/DIVU quotient=all ones; REM/REMU result=rs1_val.
//   signed overflow (rs1=0x8000_0000, rs2=0xFFFF_FFFF): DIV->0x8000_0000, REM->0.
//  CALC: one iteration per cycle, counter 0..XLEN-1. Edge XLEN (32) does the last
//   iteration, applies sign fix-up, loads write_data, goes DONE.
//   Mul: unsigned shift-add on magnitudes into 2*XLEN product; negate product if
//    signed-operand signs differ. MUL=low XLEN; MULH/MULHSU/MULHU=high XLEN.
//    MULH: both signed; MULHSU: rs1 signed, rs2 unsigned; MULHU: both unsigned.
//   Div: restoring shift-subtract on magnitudes. Signed: quotient negated if signs
//    differ; remainder takes dividend sign. Unsigned ops: no fix-up.
//  DONE (exactly one cycle): done=1, busy=1, wEn=(rd!=0), rd=latched rd,
//   write_data=result. Next edge -> IDLE, done/wEn drop to 0. write_data holds.
//  Latency: start in cycle T -> done in cycle T+XLEN+1 (T+33); special cases T+1.
//   busy high T+1 .. done cycle inclusive.
//  rd==0: full computation, done pulses, wEn stays 0.
//  Input operands may change after edge 0; result uses only latched values.
// TESTING
//  1 MUL 7*6, rd=5 -> done at T+33, wEn=1, rd=5, write_data=0x0000_002A; busy T+1..T+33.
//  2 MULH 0xFFFF_FFFF*0xFFFF_FFFF -> 0x0000_0000; MULHU same operands -> 0xFFFF_FFFE;
//    MULHSU 0xFFFF_FFFF*0x0000_0002 -> 0xFFFF_FFFF.
//  3 DIV -7/2 -> 0xFFFF_FFFD; REM -7/2 -> 0xFFFF_FFFF; DIVU 100/7 -> 14; REMU -> 2.
//  4 DIVU 5/0 -> done T+1, 0xFFFF_FFFF; REM 5/0 -> 5; DIV 0x8000_0000/-1 -> 0x8000_0000.
//  5 start pulsed at T+5 and T+33 during op -> ignored; exactly one done; rd=0 op -> wEn=0.
//  6 rst=1 at T+10 mid-CALC -> next cycle busy=0, no done/wEn; new start then completes normally.

Source files
------------

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: one shift-add or restoring shift-subtract
// step per cycle, sign fix-up on the final step, result driven onto the regfile write port.
module muldiv_unit #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] rs1_val,
  input  logic [XLEN-1:0] rs2_val,
  input  logic [4:0]      rd_in,
  output logic            busy,
  output logic            done,
  output logic            wEn,
  output logic [4:0]      rd,
  output logic [XLEN-1:0] write_data
);

  localparam int unsigned CNT_W = $clog2(XLEN);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

  state_t            r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic [2:0]        r_funct3;
  logic [XLEN-1:0]   r_hi;
  logic [XLEN-1:0]   r_lo;
  logic [XLEN-1:0]   r_b;
  logic              r_neg;
  logic              r_neg_rem;
  logic              r_busy;
  logic              r_done;
  logic              r_wen;
  logic [4:0]        r_rd;
  logic [XLEN-1:0]   r_wdata;

  // Request decode: operand signedness, magnitudes and the single-cycle special cases
  logic            w_in_div;
  logic            w_sgn1;
  logic            w_sgn2;
  logic            w_neg1;
  logic            w_neg2;
  logic [XLEN-1:0] w_mag1;
  logic [XLEN-1:0] w_mag2;
  logic            w_div_zero;
  logic            w_ovf;
  logic [XLEN-1:0] w_special;
  logic [XLEN-1:0] w_int_min;

  assign w_int_min  = {1'b1, {(XLEN-1){1'b0}}};
  assign w_in_div   = funct3[2];
  assign w_sgn1     = w_in_div ? ~funct3[0] : (funct3[1:0] != 2'b11);
  assign w_sgn2     = w_in_div ? ~funct3[0] : ~funct3[1];
  assign w_neg1     = w_sgn1 & rs1_val[XLEN-1];
  assign w_neg2     = w_sgn2 & rs2_val[XLEN-1];
  assign w_mag1     = w_neg1 ? -rs1_val : rs1_val;
  assign w_mag2     = w_neg2 ? -rs2_val : rs2_val;
  assign w_div_zero = w_in_div && (rs2_val == '0);
  assign w_ovf      = w_in_div && !funct3[0] && (rs1_val == w_int_min) && (rs2_val == '1);
  assign w_special  = funct3[1] ? (w_div_zero ? rs1_val : '0)
                                : (w_div_zero ? '1 : w_int_min);

  // One iteration: r_lo holds multiplier / dividend-quotient, r_hi the upper product / remainder
  logic            w_is_div;
  logic [XLEN:0]   w_add;
  logic [XLEN:0]   w_shift;
  logic [XLEN:0]   w_diff;
  logic [XLEN-1:0] w_hi_n;
  logic [XLEN-1:0] w_lo_n;

  assign w_is_div = r_funct3[2];
  assign w_add    = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_b} : {(XLEN+1){1'b0}});
  assign w_shift  = {r_hi, r_lo[XLEN-1]};
  assign w_diff   = w_shift - {1'b0, r_b};

  always_comb begin
    w_hi_n = w_add[XLEN:1];
    w_lo_n = {w_add[0], r_lo[XLEN-1:1]};
    if (w_is_div) begin
      w_hi_n = w_diff[XLEN] ? w_shift[XLEN-1:0] : w_diff[XLEN-1:0];
      w_lo_n = {r_lo[XLEN-2:0], ~w_diff[XLEN]};
    end
  end

  // Sign fix-up and result selection applied to the final iteration's outputs
  logic [2*XLEN-1:0] w_prod;
  logic [2*XLEN-1:0] w_prod_f;
  logic [XLEN-1:0]   w_result;

  assign w_prod   = {w_hi_n, w_lo_n};
  assign w_prod_f = r_neg ? -w_prod : w_prod;

  always_comb begin
    w_result = w_prod_f[2*XLEN-1:XLEN];
    if (w_is_div) begin
      if (r_funct3[1]) w_result = r_neg_rem ? -w_hi_n : w_hi_n;
      else             w_result = r_neg ? -w_lo_n : w_lo_n;
    end else if (r_funct3[1:0] == 2'b00) begin
      w_result = w_prod_f[XLEN-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_funct3  <= '0;
      r_hi      <= '0;
      r_lo      <= '0;
      r_b       <= '0;
      r_neg     <= 1'b0;
      r_neg_rem <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_wen     <= 1'b0;
      r_rd      <= '0;
      r_wdata   <= '0;
    end else begin
      r_done <= 1'b0;
      r_wen  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_funct3  <= funct3;
            r_rd      <= rd_in;
            r_cnt     <= '0;
            r_busy    <= 1'b1;
            r_hi      <= '0;
            r_lo      <= w_in_div ? w_mag1 : w_mag2;
            r_b       <= w_in_div ? w_mag2 : w_mag1;
            r_neg     <= w_neg1 ^ w_neg2;
            r_neg_rem <= w_neg1;
            if (w_div_zero || w_ovf) begin
              r_wdata <= w_special;
              r_done  <= 1'b1;
              r_wen   <= (rd_in != 5'd0);
              r_state <= S_DONE;
            end else begin
              r_state <= S_CALC;
            end
          end
        end
        S_CALC: begin
          r_hi  <= w_hi_n;
          r_lo  <= w_lo_n;
          r_cnt <= r_cnt + CNT_W'(1);
          if (r_cnt == CNT_W'(XLEN-1)) begin
            r_wdata <= w_result;
            r_done  <= 1'b1;
            r_wen   <= (r_rd != 5'd0);
            r_state <= S_DONE;
          end
        end
        S_DONE: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign busy       = r_busy;
  assign done       = r_done;
  assign wEn        = r_wen;
  assign rd         = r_rd;
  assign write_data = r_wdata;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed testbench for muldiv_unit: hand-computed RV32M results, latency,
// busy/done/wEn behaviour, ignored starts and mid-operation reset.
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [2:0]  funct3;
  logic [31:0] rs1_val;
  logic [31:0] rs2_val;
  logic [4:0]  rd_in;
  logic        busy;
  logic        done;
  logic        wEn;
  logic [4:0]  rd;
  logic [31:0] write_data;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  muldiv_unit #(.XLEN(32)) dut (
    .clk(clk), .rst(rst), .start(start), .funct3(funct3),
    .rs1_val(rs1_val), .rs2_val(rs2_val), .rd_in(rd_in),
    .busy(busy), .done(done), .wEn(wEn), .rd(rd), .write_data(write_data)
  );

  // Issue one op (start high in cycle T), scramble inputs afterwards, wait (bounded) for done.
  // lat = cycles after T at which done was seen; busy_ok = busy held from T+1 through done.
  task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] d, output int lat, output logic [31:0] wd,
                        output logic we, output logic [4:0] rdo, output logic busy_ok);
    @(negedge clk);
    funct3 = f; rs1_val = a; rs2_val = b; rd_in = d; start = 1'b1;
    @(negedge clk);
    start = 1'b0; rs1_val = 32'hDEAD_BEEF; rs2_val = 32'h1234_5678; funct3 = ~f; rd_in = ~d;
    lat = 1; busy_ok = 1'b1;
    while (!done && lat < 100) begin
      if (!busy) busy_ok = 1'b0;
      @(negedge clk);
      lat++;
    end
    if (!busy) busy_ok = 1'b0;
    wd = write_data; we = wEn; rdo = rd;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; funct3 = '0; rs1_val = '0; rs2_val = '0; rd_in = '0;
    repeat (2) @(negedge clk);
    checks++;
    if ({busy, done, wEn} !== 3'b000) begin
      errors++; $display("FAIL reset_flags got %b want 000", {busy, done, wEn});
    end
    checks++;
    if (rd !== 5'd0 || write_data !== 32'd0) begin
      errors++; $display("FAIL reset_data got rd=%0d wd=%h want rd=0 wd=0", rd, write_data);
    end
    rst = 1'b0;
  endtask

  task automatic test_mul();
    int lat; logic [31:0] wd; logic we; logic [4:0] rdo; logic bok;
    run_op(3'b000, 32'd7, 32'd6, 5'd5, lat, wd, we, rdo, bok);
    checks++;
    if (lat !== 33) begin errors++; $display("FAIL mul_latency got %0d want 33", lat); end
    checks++;
    if (wd !== 32'h0000_002A) begin errors++; $display("FAIL mul_data got %h want 0000002a", wd); end
    checks++;
    if (we !== 1'b1 || rdo !== 5'd5) begin
      errors++; $display("FAIL mul_wport got wEn=%b rd=%0d want wEn=1 rd=5", we, rdo);
    end
    checks++;
    if (bok !== 1'b1) begin errors++; $display("FAIL mul_busy got %b want 1", bok); end
    @(negedge clk);
    checks++;
    if ({busy, done, wEn} !== 3'b000 || write_data !== 32'h0000_002A) begin
      errors++; $display("FAIL mul_after got flags=%b wd=%h want 000 0000002a", {busy, done, wEn}, write_data);
    end
  endtask

  task automatic test_mulh();
    int lat; logic [31:0] wd; logic we; logic [4:0] rdo; logic bok;
    run_op(3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd1, lat, wd, we, rdo, bok);
    checks++;
    if (wd !== 32'h0000_0000 || lat !== 33) begin
      errors++; $display("FAIL mulh got %h lat %0d want 00000000 lat 33", wd, lat);
    end
    run_op(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2, lat, wd, we, rdo, bok);
    checks++;
    if (wd !== 32'hFFFF_FFFE) begin errors++; $display("FAIL mulhu got %h want fffffffe", wd); end
    run_op(3'b010, 32'hFFFF_FFFF, 32'h0000_0002, 5'd3, lat, wd, we, rdo, bok);
    checks++;
    if (wd !== 32'hFFFF_FFFF) begin errors++; $display("FAIL mulhsu got %h want ffffffff", wd); end
    run_op(3'b000, 32'hFFFF_FFFD, 32'd5, 5'd4, lat, wd, we, rdo, bok);
    checks++;
    if (wd !== 32'hFFFF_FFF1) begin errors++; $display("FAIL mul_neg got %h want fffffff1", wd); end
  endtask

  task automatic test_div();
    int lat; logic [31:0] wd; logic we; logic [4:0] rdo; logic bok;
    run_op(3'b100, 32'hFFFF_FFF9, 32'd2, 5'd6, lat, wd, we, rdo, bok);
    checks++;
    if (wd !== 32'hFFFF_FFFD || lat !== 33) begin
      errors++; $display("FAIL div got %h lat %0d want fffffffd lat 33", wd, lat);
    end
    run_op(3'b110, 32'hFFFF_FFF9, 32'd2, 5'd7, lat, wd, we, rdo, bok);
    checks++;
    if (wd !== 32'hFFFF_FFFF) begin errors++; $display("FAIL rem got %h want ffffffff", wd); end
    run_op(3'b101, 32'd100, 32'd7, 5'd8, lat, wd, we, rdo, bok);
    checks++;
    if (wd !== 32'd14) begin errors++; $display("FAIL divu got %h want 0000000e", wd); end
    run_op(3'b111, 32'd100, 32'd7, 5'd9, lat, wd, we, rdo, bok);
    checks++;
    if (wd !== 32'd2) begin errors++; $display("FAIL remu got %h want 00000002", wd); end
    run_op(3'b101, 32'hFFFF_FFF9, 32'd2, 5'd10, lat, wd, we, rdo, bok);
    checks++;
    if (wd !== 32'h7FFF_FFFC) begin errors++; $display("FAIL divu_big got %h want 7ffffffc", wd); end
  endtask

  task automatic test_special();
    int lat; logic [31:0] wd; logic we; logic [4:0] rdo; logic bok;
    run_op(3'b101, 32'd5, 32'd0, 5'd11, lat, wd, we, rdo, bok);
    checks++;
    if (lat !== 1 || wd !== 32'hFFFF_FFFF || we !== 1'b1 || bok !== 1'b1) begin
      errors++; $display("FAIL divu_zero got lat %0d wd %h wEn %b busy %b want 1 ffffffff 1 1", lat, wd, we, bok);
    end
    run_op(3'b110, 32'd5, 32'd0, 5'd12, lat, wd, we, rdo, bok);
    checks++;
    if (lat !== 1 || wd !== 32'd5) begin
      errors++; $display("FAIL rem_zero got lat %0d wd %h want 1 00000005", lat, wd);
    end
    run_op(3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 5'd13, lat, wd, we, rdo, bok);
    checks++;
    if (lat !== 1 || wd !== 32'h8000_0000) begin
      errors++; $display("FAIL div_ovf got lat %0d wd %h want 1 80000000", lat, wd);
    end
    run_op(3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 5'd14, lat, wd, we, rdo, bok);
    checks++;
    if (lat !== 1 || wd !== 32'd0) begin
      errors++; $display("FAIL rem_ovf got lat %0d wd %h want 1 00000000", lat, wd);
    end
  endtask

  // Starts at T+5 (CALC) and T+33 (DONE) must be dropped; rd=0 must suppress wEn.
  task automatic test_ignore_start();
    int ndone = 0; int nwen = 0; int dlat = 0;
    @(negedge clk);
    funct3 = 3'b000; rs1_val = 32'd3; rs2_val = 32'd4; rd_in = 5'd0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int c = 1; c <= 80; c++) begin
      if (done) begin ndone++; dlat = c; end
      if (wEn) nwen++;
      start = (c == 5 || c == 33);
      @(negedge clk);
    end
    start = 1'b0;
    checks++;
    if (ndone !== 1 || dlat !== 33) begin
      errors++; $display("FAIL ignore_start got dones %0d at %0d want 1 at 33", ndone, dlat);
    end
    checks++;
    if (nwen !== 0) begin errors++; $display("FAIL rd0_wen got %0d want 0", nwen); end
    checks++;
    if (write_data !== 32'd12 || busy !== 1'b0) begin
      errors++; $display("FAIL rd0_data got wd %h busy %b want 0000000c 0", write_data, busy);
    end
  endtask

  task automatic test_reset_mid();
    int lat; logic [31:0] wd; logic we; logic [4:0] rdo; logic bok;
    int stray = 0;
    @(negedge clk);
    funct3 = 3'b101; rs1_val = 32'd100; rs2_val = 32'd7; rd_in = 5'd3; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int c = 1; c < 10; c++) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if ({busy, done, wEn} !== 3'b000 || write_data !== 32'd0) begin
      errors++; $display("FAIL reset_mid got flags %b wd %h want 000 00000000", {busy, done, wEn}, write_data);
    end
    for (int c = 0; c < 40; c++) begin
      if (done || wEn || busy) stray++;
      @(negedge clk);
    end
    checks++;
    if (stray !== 0) begin errors++; $display("FAIL reset_abort got %0d active cycles want 0", stray); end
    run_op(3'b100, 32'hFFFF_FFF9, 32'd2, 5'd15, lat, wd, we, rdo, bok);
    checks++;
    if (lat !== 33 || wd !== 32'hFFFF_FFFD || we !== 1'b1 || rdo !== 5'd15) begin
      errors++; $display("FAIL post_reset got lat %0d wd %h wEn %b rd %0d want 33 fffffffd 1 15", lat, wd, we, rdo);
    end
  endtask

  initial begin
    test_reset();
    test_mul();
    test_mulh();
    test_div();
    test_special();
    test_ignore_start();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
